// File: rtl/pipelined_control_unit.sv
// Registered RV32I control decode with a data-bus req/ack sequencer.
// Memory ops stall the pipeline through MEM (bus wait) and an optional FILL phase.
module pipelined_control_unit #(
  parameter int unsigned LOAD_FILL   = 1,
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       bus_ack,
  output logic       cs_valid,
  output logic [2:0] cs_imm_src,
  output logic       cs_reg_write,
  output logic       cs_reg_1_zero,
  output logic       cs_alu_src,
  output logic       cs_alu_pc,
  output logic [1:0] cs_alu_control,
  output logic [1:0] cs_mem_to_reg,
  output logic [1:0] cs_branch_op,
  output logic       cs_end_isr,
  output logic [1:0] cs_mem_width,
  output logic       cs_load_signed,
  output logic       bus_read,
  output logic       bus_write,
  output logic       stall,
  output logic       bus_fault
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_MRET   = 7'b1111111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int FILL_LAST_I = (LOAD_FILL > 0) ? int'(LOAD_FILL) - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_LAST_I);

  typedef enum logic [1:0] {RUN = 2'd0, MEM = 2'd1, FILL = 2'd2} state_t;

  typedef struct packed {
    logic [2:0] imm_src;
    logic       reg_write;
    logic       reg_1_zero;
    logic       alu_src;
    logic       alu_pc;
    logic [1:0] alu_control;
    logic [1:0] mem_to_reg;
    logic [1:0] branch_op;
    logic       end_isr;
    logic [1:0] mem_width;
    logic       load_signed;
  } cs_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cs_t              cs_q, cs_d, dec;
  logic             cs_valid_q, cs_valid_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             fault_q, fault_d;

  always_comb begin
    dec = '0;
    case (opcode)
      OP_R:      {dec.imm_src, dec.reg_write, dec.reg_1_zero, dec.alu_src, dec.alu_pc, dec.alu_control,
                  dec.mem_to_reg, dec.branch_op, dec.end_isr} = 14'b000_1_0_0_0_11_00_00_0;
      OP_IMM:    {dec.imm_src, dec.reg_write, dec.reg_1_zero, dec.alu_src, dec.alu_pc, dec.alu_control,
                  dec.mem_to_reg, dec.branch_op, dec.end_isr} = 14'b001_1_0_1_0_10_00_00_0;
      OP_BRANCH: {dec.imm_src, dec.reg_write, dec.reg_1_zero, dec.alu_src, dec.alu_pc, dec.alu_control,
                  dec.mem_to_reg, dec.branch_op, dec.end_isr} = 14'b011_0_0_0_0_01_00_01_0;
      OP_JAL:    {dec.imm_src, dec.reg_write, dec.reg_1_zero, dec.alu_src, dec.alu_pc, dec.alu_control,
                  dec.mem_to_reg, dec.branch_op, dec.end_isr} = 14'b100_1_1_1_0_00_10_10_0;
      OP_JALR:   {dec.imm_src, dec.reg_write, dec.reg_1_zero, dec.alu_src, dec.alu_pc, dec.alu_control,
                  dec.mem_to_reg, dec.branch_op, dec.end_isr} = 14'b001_1_0_1_0_00_10_11_0;
      OP_LOAD:   {dec.imm_src, dec.reg_write, dec.reg_1_zero, dec.alu_src, dec.alu_pc, dec.alu_control,
                  dec.mem_to_reg, dec.branch_op, dec.end_isr} = 14'b001_1_0_1_0_00_01_00_0;
      OP_STORE:  {dec.imm_src, dec.reg_write, dec.reg_1_zero, dec.alu_src, dec.alu_pc, dec.alu_control,
                  dec.mem_to_reg, dec.branch_op, dec.end_isr} = 14'b010_0_0_1_0_00_00_00_0;
      OP_LUI:    {dec.imm_src, dec.reg_write, dec.reg_1_zero, dec.alu_src, dec.alu_pc, dec.alu_control,
                  dec.mem_to_reg, dec.branch_op, dec.end_isr} = 14'b000_1_1_1_0_00_00_00_0;
      OP_MRET:   {dec.imm_src, dec.reg_write, dec.reg_1_zero, dec.alu_src, dec.alu_pc, dec.alu_control,
                  dec.mem_to_reg, dec.branch_op, dec.end_isr} = 14'b000_0_0_0_0_00_00_00_1;
      OP_AUIPC:  {dec.imm_src, dec.reg_write, dec.reg_1_zero, dec.alu_src, dec.alu_pc, dec.alu_control,
                  dec.mem_to_reg, dec.branch_op, dec.end_isr} = 14'b000_1_0_1_1_00_00_00_0;
      default:   dec = '0;
    endcase
    if (opcode == OP_LOAD || opcode == OP_STORE) begin
      case (func3[1:0])
        2'b00:   dec.mem_width = 2'b10;
        2'b01:   dec.mem_width = 2'b01;
        default: dec.mem_width = 2'b00;
      endcase
    end
    dec.load_signed = (opcode == OP_LOAD) ? ~func3[2] : 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cs_d       = cs_q;
    cs_valid_d = 1'b0;
    rd_d       = rd_q;
    wr_d       = wr_q;
    fault_d    = 1'b0;
    case (state_q)
      RUN: begin
        if (instr_valid) begin
          cs_d       = dec;
          cs_valid_d = 1'b1;
          cnt_d      = '0;
          if (opcode == OP_LOAD) begin
            state_d = MEM;
            rd_d    = 1'b1;
          end else if (opcode == OP_STORE) begin
            state_d = MEM;
            wr_d    = 1'b1;
          end
        end
      end
      MEM: begin
        // An ack arriving on the timeout cycle still completes the access.
        if (bus_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          cnt_d   = '0;
          state_d = (rd_q && LOAD_FILL > 0) ? FILL : RUN;
        end else if (cnt_q == TO_LAST) begin
          rd_d             = 1'b0;
          wr_d             = 1'b0;
          cnt_d            = '0;
          state_d          = RUN;
          fault_d          = 1'b1;
          cs_d.reg_write   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FILL: begin
        if (cnt_q == FILL_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      cs_q       <= '0;
      cs_valid_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      cs_valid_q <= cs_valid_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      fault_q    <= fault_d;
    end
  end

  assign cs_valid       = cs_valid_q;
  assign cs_imm_src     = cs_q.imm_src;
  assign cs_reg_write   = cs_q.reg_write;
  assign cs_reg_1_zero  = cs_q.reg_1_zero;
  assign cs_alu_src     = cs_q.alu_src;
  assign cs_alu_pc      = cs_q.alu_pc;
  assign cs_alu_control = cs_q.alu_control;
  assign cs_mem_to_reg  = cs_q.mem_to_reg;
  assign cs_branch_op   = cs_q.branch_op;
  assign cs_end_isr     = cs_q.end_isr;
  assign cs_mem_width   = cs_q.mem_width;
  assign cs_load_signed = cs_q.load_signed;
  assign bus_read       = rd_q;
  assign bus_write      = wr_q;
  assign stall          = (state_q != RUN);
  assign bus_fault      = fault_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios plus random instruction streams
// checked cycle by cycle against a timeline model derived from ack delay and fill length.
module tb_pipelined_control_unit;

  localparam int T  = 4;
  localparam int LF = 2;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    int         d;   // MEM cycle carrying the ack; > T means never acked
  } ins_t;

  logic clk = 1'b0;
  logic reset;
  logic instr_valid, bus_ack;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic cs_valid, cs_reg_write, cs_reg_1_zero, cs_alu_src, cs_alu_pc, cs_end_isr, cs_load_signed;
  logic [2:0] cs_imm_src;
  logic [1:0] cs_alu_control, cs_mem_to_reg, cs_branch_op, cs_mem_width;
  logic bus_read, bus_write, stall, bus_fault;

  logic nf_instr_valid, nf_bus_ack;
  logic [6:0] nf_opcode;
  logic [2:0] nf_func3;
  logic nf_cs_valid, nf_cs_reg_write, nf_cs_reg_1_zero, nf_cs_alu_src, nf_cs_alu_pc, nf_cs_end_isr;
  logic nf_cs_load_signed;
  logic [2:0] nf_cs_imm_src;
  logic [1:0] nf_cs_alu_control, nf_cs_mem_to_reg, nf_cs_branch_op, nf_cs_mem_width;
  logic nf_bus_read, nf_bus_write, nf_stall, nf_bus_fault;

  int compared = 0;
  int mismatched = 0;
  ins_t prog[$];

  always #5 clk = ~clk;

  pipelined_control_unit #(.LOAD_FILL(LF), .BUS_TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode), .func3(func3),
    .bus_ack(bus_ack), .cs_valid(cs_valid), .cs_imm_src(cs_imm_src), .cs_reg_write(cs_reg_write),
    .cs_reg_1_zero(cs_reg_1_zero), .cs_alu_src(cs_alu_src), .cs_alu_pc(cs_alu_pc),
    .cs_alu_control(cs_alu_control), .cs_mem_to_reg(cs_mem_to_reg), .cs_branch_op(cs_branch_op),
    .cs_end_isr(cs_end_isr), .cs_mem_width(cs_mem_width), .cs_load_signed(cs_load_signed),
    .bus_read(bus_read), .bus_write(bus_write), .stall(stall), .bus_fault(bus_fault)
  );

  pipelined_control_unit #(.LOAD_FILL(0), .BUS_TIMEOUT(16), .CNT_W(8)) u_nf (
    .clk(clk), .reset(reset), .instr_valid(nf_instr_valid), .opcode(nf_opcode), .func3(nf_func3),
    .bus_ack(nf_bus_ack), .cs_valid(nf_cs_valid), .cs_imm_src(nf_cs_imm_src),
    .cs_reg_write(nf_cs_reg_write), .cs_reg_1_zero(nf_cs_reg_1_zero), .cs_alu_src(nf_cs_alu_src),
    .cs_alu_pc(nf_cs_alu_pc), .cs_alu_control(nf_cs_alu_control), .cs_mem_to_reg(nf_cs_mem_to_reg),
    .cs_branch_op(nf_cs_branch_op), .cs_end_isr(nf_cs_end_isr), .cs_mem_width(nf_cs_mem_width),
    .cs_load_signed(nf_cs_load_signed), .bus_read(nf_bus_read), .bus_write(nf_bus_write),
    .stall(nf_stall), .bus_fault(nf_bus_fault)
  );

  // Expected bundle: {imm_src, reg_write, reg_1_zero, alu_src, alu_pc, alu_control,
  // mem_to_reg, branch_op, end_isr, mem_width, load_signed}; reg_write is bit 13.
  function automatic logic [16:0] ref_bundle(input logic [6:0] op, input logic [2:0] f3);
    logic [13:0] base;
    logic [1:0]  mw;
    logic        ls;
    case (op)
      7'b0110011: base = 14'b000_1_0_0_0_11_00_00_0;
      7'b0010011: base = 14'b001_1_0_1_0_10_00_00_0;
      7'b1100011: base = 14'b011_0_0_0_0_01_00_01_0;
      7'b1101111: base = 14'b100_1_1_1_0_00_10_10_0;
      7'b1100111: base = 14'b001_1_0_1_0_00_10_11_0;
      7'b0000011: base = 14'b001_1_0_1_0_00_01_00_0;
      7'b0100011: base = 14'b010_0_0_1_0_00_00_00_0;
      7'b0110111: base = 14'b000_1_1_1_0_00_00_00_0;
      7'b1111111: base = 14'b000_0_0_0_0_00_00_00_1;
      7'b0010111: base = 14'b000_1_0_1_1_00_00_00_0;
      default:    base = 14'b0;
    endcase
    mw = 2'b00;
    if (op == OP_LOAD || op == OP_STORE)
      mw = (f3[1:0] == 2'b00) ? 2'b10 : (f3[1:0] == 2'b01) ? 2'b01 : 2'b00;
    ls = (op == OP_LOAD) ? ~f3[2] : 1'b0;
    return {base, mw, ls};
  endfunction

  function automatic logic [16:0] dut_bundle();
    return {cs_imm_src, cs_reg_write, cs_reg_1_zero, cs_alu_src, cs_alu_pc, cs_alu_control,
            cs_mem_to_reg, cs_branch_op, cs_end_isr, cs_mem_width, cs_load_signed};
  endfunction

  // Feeds prog back to back; each instruction's stall window is m MEM cycles
  // (m = ack cycle or T on timeout) plus LF fill cycles for an acked load.
  task automatic run_program(input string tag);
    ins_t        it;
    logic [16:0] exp_b;
    logic        ld, st, mem, flt;
    int          m, total;
    foreach (prog[k]) begin
      it    = prog[k];
      exp_b = ref_bundle(it.op, it.f3);
      ld    = (it.op == OP_LOAD);
      st    = (it.op == OP_STORE);
      mem   = ld || st;
      m     = mem ? ((it.d <= T) ? it.d : T) : 0;
      flt   = mem && (it.d > T);
      total = mem ? m + ((ld && !flt) ? LF : 0) : 0;
      instr_valid = 1'b1; opcode = it.op; func3 = it.f3; bus_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      compared++;
      if ({cs_valid, dut_bundle(), bus_read, bus_write, stall, bus_fault} !==
          {1'b1, exp_b, ld, st, mem, 1'b0}) begin
        mismatched++;
        $display("FAIL %s accept #%0d op=%b: got %h want %h", tag, k, it.op,
                 {cs_valid, dut_bundle(), bus_read, bus_write, stall, bus_fault},
                 {1'b1, exp_b, ld, st, mem, 1'b0});
      end
      for (int j = 1; j <= total; j++) begin
        opcode = 7'($urandom); func3 = 3'($urandom); instr_valid = 1'($urandom_range(0, 1));
        bus_ack = (j <= m) ? (j == it.d) : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (flt && j >= m) exp_b[13] = 1'b0;
        compared++;
        if ({cs_valid, dut_bundle(), bus_read, bus_write, stall, bus_fault} !==
            {1'b0, exp_b, ld && (j + 1 <= m), st && (j + 1 <= m), (j + 1 <= total), flt && (j == m)}) begin
          mismatched++;
          $display("FAIL %s hold #%0d cyc=%0d: got %h want %h", tag, k, j,
                   {cs_valid, dut_bundle(), bus_read, bus_write, stall, bus_fault},
                   {1'b0, exp_b, ld && (j + 1 <= m), st && (j + 1 <= m), (j + 1 <= total), flt && (j == m)});
        end
      end
    end
    instr_valid = 1'b0; bus_ack = 1'b0;
    prog.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b1; opcode = OP_LOAD; func3 = 3'b000; bus_ack = 1'b1;
    nf_instr_valid = 1'b0; nf_opcode = 7'b0; nf_func3 = 3'b0; nf_bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({cs_valid, dut_bundle(), bus_read, bus_write, stall, bus_fault} !== 22'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0",
               {cs_valid, dut_bundle(), bus_read, bus_write, stall, bus_fault});
    end
    reset = 1'b0; instr_valid = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic test_alu_mix();
    prog.push_back('{7'b0110011, 3'b000, 0});
    prog.push_back('{7'b0010011, 3'b101, 0});
    prog.push_back('{7'b0110111, 3'b011, 0});
    run_program("alu_mix");
  endtask

  task automatic test_load_fill();
    prog.push_back('{OP_LOAD, 3'b100, 3});
    prog.push_back('{7'b1100011, 3'b001, 0});
    run_program("load_fill");
  endtask

  task automatic test_store();
    prog.push_back('{OP_STORE, 3'b001, 1});
    prog.push_back('{7'b1101111, 3'b000, 0});
    run_program("store");
  endtask

  task automatic test_timeout();
    prog.push_back('{OP_LOAD, 3'b010, T + 1});
    prog.push_back('{OP_LOAD, 3'b000, T});
    prog.push_back('{OP_STORE, 3'b010, T + 1});
    prog.push_back('{7'b0010111, 3'b000, 0});
    run_program("timeout");
  endtask

  task automatic test_unknown();
    prog.push_back('{7'b0001111, 3'b111, 0});
    prog.push_back('{7'b1100111, 3'b000, 0});
    run_program("unknown");
  endtask

  task automatic test_reset_mid();
    instr_valid = 1'b1; opcode = OP_LOAD; func3 = 3'b010; bus_ack = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    compared++;
    if ({bus_read, stall} !== 2'b11) begin
      mismatched++;
      $display("FAIL reset_mid_pre: got rd/stall=%b want 11", {bus_read, stall});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    compared++;
    if ({cs_valid, dut_bundle(), bus_read, bus_write, stall, bus_fault} !== 22'b0) begin
      mismatched++;
      $display("FAIL reset_mid_clear: got %h want 0",
               {cs_valid, dut_bundle(), bus_read, bus_write, stall, bus_fault});
    end
    reset = 1'b0; instr_valid = 1'b1; opcode = 7'b1111111; func3 = 3'b000;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    compared++;
    if ({cs_valid, cs_end_isr, stall, bus_fault} !== 4'b1100) begin
      mismatched++;
      $display("FAIL reset_mid_mret: got %b want 1100", {cs_valid, cs_end_isr, stall, bus_fault});
    end
    @(posedge clk); #1;
    compared++;
    if ({cs_valid, cs_end_isr, bus_fault} !== 3'b010) begin
      mismatched++;
      $display("FAIL reset_mid_pulse: got %b want 010", {cs_valid, cs_end_isr, bus_fault});
    end
  endtask

  task automatic test_no_fill();
    int stall_cycles;
    nf_instr_valid = 1'b1; nf_opcode = OP_LOAD; nf_func3 = 3'b001; nf_bus_ack = 1'b0;
    @(posedge clk); #1;
    nf_instr_valid = 1'b0; nf_bus_ack = 1'b1;
    compared++;
    if ({nf_cs_valid, nf_stall, nf_bus_read, nf_cs_mem_width, nf_cs_load_signed} !== 6'b111011) begin
      mismatched++;
      $display("FAIL no_fill_accept: got %b want 111011",
               {nf_cs_valid, nf_stall, nf_bus_read, nf_cs_mem_width, nf_cs_load_signed});
    end
    stall_cycles = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      nf_bus_ack = 1'b0;
      if (nf_stall) stall_cycles++;
    end
    compared++;
    if (stall_cycles !== 1 || nf_bus_read !== 1'b0 || nf_bus_fault !== 1'b0) begin
      mismatched++;
      $display("FAIL no_fill_stall: got stall_cycles=%0d rd=%b fault=%b want 1/0/0",
               stall_cycles, nf_bus_read, nf_bus_fault);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [12];
    logic [6:0] op;
    ops = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111, OP_LOAD,
            OP_STORE, 7'b0110111, 7'b1111111, 7'b0010111, 7'b0001111, 7'b0000000};
    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 11)];
      prog.push_back('{op, 3'($urandom),
                       (op == OP_LOAD || op == OP_STORE) ? int'($urandom_range(1, T + 1)) : 0});
    end
    run_program("random");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_mix();
    test_load_fill();
    test_store();
    test_timeout();
    test_unknown();
    test_reset_mid();
    test_no_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Registered, parametrised control unit for the RV32I core. It decodes opcode/func3 into the core's control-signal bundle one cycle after an instruction is accepted. It sequences multi-cycle data-bus accesses with a req/ack handshake, and holds the pipeline with `stall` for a configurable load-fill latency. It raises `bus_fault` when an access is not acknowledged within a timeout. It sits between the fetch register and the datapath.

Parameters:
LOAD_FILL, 1, extra stall cycles after a load ack (0..15); 0 = no fill state.
BUS_TIMEOUT, 16, max wait cycles for bus_ack before fault (2..255).
CNT_W, 8, width of internal wait/fill counter; must hold max(LOAD_FILL, BUS_TIMEOUT).

Ports:
clk  in  1  core clock, rising edge.
reset  in  1  synchronous, active-high reset.
instr_valid  in  1  opcode/func3 valid this cycle.
opcode  in  7  instruction[6:0].
func3  in  3  instruction[14:12].
bus_ack  in  1  data bus completes the access this cycle.
cs_valid  out  1  one-cycle pulse: registered control bundle is valid.
cs_imm_src  out  3  immediate format.
cs_reg_write  out  1  register file write enable.
cs_reg_1_zero  out  1  force rs1 = x0.
cs_alu_src  out  1  ALU B = immediate.
cs_alu_pc  out  1  ALU A = PC.
cs_alu_control  out  2  ALU decode mode.
cs_mem_to_reg  out  2  writeback select.
cs_branch_op  out  2  branch operation.
cs_end_isr  out  1  return from ISR.
cs_mem_width  out  2  10 byte, 01 half, 00 word.
cs_load_signed  out  1  sign-extend load.
bus_read  out  1  data bus read request, held until ack/fault.
bus_write  out  1  data bus write request, held until ack/fault.
stall  out  1  pipeline hold.
bus_fault  out  1  one-cycle pulse on access timeout.

Behaviour:
- Reset: state RUN, counter 0; every output 0 (decode bundle registers included).
- Decode table (imm_src, reg_write, reg_1_zero, alu_src, alu_pc, alu_control, mem_to_reg, branch_op, end_isr):
  - 0110011: 000,1,0,0,0,11,00,00,0
  - 0010011: 001,1,0,1,0,10,00,00,0
  - 1100011: 011,0,0,0,0,01,00,01,0
  - 1101111: 100,1,1,1,0,00,10,10,0
  - 1100111: 001,1,0,1,0,00,10,11,0
  - 0000011: 001,1,0,1,0,00,01,00,0
  - 0100011: 010,0,0,1,0,00,00,00,0
  - 0110111: 000,1,1,1,0,00,00,00,0
  - 1111111: 000,0,0,0,0,00,00,00,1
  - 0010111: 000,1,0,1,1,00,00,00,0
  - others: all 0 (NOP).
- cs_mem_width: from func3[1:0] (00→10, 01→01, else 00) for load/store only; 00 otherwise.
- cs_load_signed: ~func3[2] for load only.
- Acceptance: instr_valid && state==RUN. Next edge: bundle registers load, cs_valid=1 for exactly that cycle. Bundle holds its value until the next acceptance.
- States:
  - RUN: stall=0. Accepted load → MEM with bus_read=1. Accepted store → MEM with bus_write=1. Other opcodes stay in RUN (throughput 1/cycle).
  - MEM: stall=1, request held, counter increments each cycle without ack.
    - bus_ack: request drops at the next edge, counter cleared. Store → RUN. Load → FILL if LOAD_FILL>0, else RUN.
    - Counter reaching BUS_TIMEOUT-1 with no ack: next edge → RUN, request dropped, bus_fault=1 for one cycle, cs_reg_write cleared (no writeback).
    - Ack on the same cycle as timeout: ack wins, no fault.
  - FILL: stall=1, counts LOAD_FILL cycles, then → RUN.
- instr_valid ignored whenever state≠RUN; upstream holds the instruction while stall=1.
- Memory instruction latency: accept at edge N; stall high from N+1; earliest RUN at N+2 (store, ack in first MEM cycle) or N+2+LOAD_FILL (load).
- bus_read and bus_write never both high; both registered, never combinational from inputs.
- bus_ack outside MEM is ignored.
- Reset mid-access: next edge forces RUN, drops the request, clears all outputs; no fault pulse.

Test Plan:
- ALU mix: back-to-back 0110011, 0010011, 0110111 with instr_valid=1 → cs_valid high 3 consecutive cycles; bundles match table; stall stays 0.
- Load 0000011 func3=100, LOAD_FILL=2, ack on 3rd MEM cycle → bus_read high 3 cycles; stall high 5 cycles; cs_mem_width=10, cs_load_signed=0; new instruction accepted the cycle stall falls.
- Store func3=001, ack same cycle as first MEM cycle → bus_write high 1 cycle; cs_mem_width=01; stall 1 cycle; instr_valid during stall not accepted.
- Timeout, BUS_TIMEOUT=4, load never acked → bus_read high 4 cycles, then bus_fault pulse 1 cycle, cs_reg_write=0, state RUN; ack exactly on 4th cycle → no fault.
- Reset asserted during MEM → next cycle all outputs 0, bus_read 0, stall 0; post-reset 1111111 accepted → cs_end_isr=1, cs_valid pulse.
- Unknown opcode 0001111 → cs_valid pulse, all bundle fields 0; LOAD_FILL=0 load with immediate ack → stall exactly 1 cycle.
